alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Writeback stage directly downstream of the 8-bit ALU. Captures the ALU result,
//  carry/borrow and zero outputs each executed instruction and commits them to the
//  W register, a registered file-register write port, or the STATUS C/Z flags.
//  Drives status_c back to the ALU cin. Generates the one-cycle skip request for
//  DECFSZ/INCFSZ. Provides a bypass for a read of the address being written.
// PARAMETERS
//  STATUS_ADDR  7'h03  file address of STATUS; file writes here also load C/Z
//  W_RESET      8'h00  reset value of W register
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous reset, active high
//  wb_valid    in   1  ALU outputs belong to an instruction to commit this cycle
//  hold        in   1  pipeline freeze; overrides wb_valid
//  alu_y       in   8  ALU result
//  alu_cout    in   1  ALU carry out (already borrow-corrected for SUB)
//  alu_zout    in   1  ALU zero flag (alu_y == 0)
//  wb_dest     in   1  0 = write W, 1 = write file register wb_addr
//  wb_addr     in   7  destination file address
//  upd_c       in   1  instruction updates C
//  upd_z       in   1  instruction updates Z
//  skip_en     in   1  instruction skips next when result is zero
//  byp_addr    in   7  file address being read by the upstream stage
//  w_out       out  8  W register
//  status_c    out  1  carry flag; wired to ALU cin
//  status_z    out  1  zero flag
//  status_out  out  8  STATUS image {5'b0, Z, 1'b0, C}
//  fw_we       out  1  file write strobe, registered, one-cycle pulse
//  fw_addr     out  7  file write address, registered
//  fw_data     out  8  file write data, registered
//  skip_out    out  1  skip next instruction, registered, one-cycle pulse
//  byp_hit     out  1  fw_we & (byp_addr == fw_addr), combinational
//  byp_data    out  8  fw_data, valid when byp_hit
// BEHAVIOUR
//  - Reset (async): w_out=W_RESET, status_c=0, status_z=0, fw_we=0, fw_addr=0,
//    fw_data=0, skip_out=0. Reset mid-operation drops any pending write/skip.
//  - Commit = wb_valid & ~hold, sampled at rising clk; latency one cycle.
//  - Commit, wb_dest=0: w_out<=alu_y; fw_we<=0.
//  - Commit, wb_dest=1: fw_we<=1, fw_addr<=wb_addr, fw_data<=alu_y; W unchanged.
//  - Flags on commit: upd_c -> status_c<=alu_cout; upd_z -> status_z<=alu_zout.
//  - Commit, wb_dest=1, wb_addr==STATUS_ADDR: status_c<=alu_y[0], status_z<=alu_y[2],
//    except a bit whose upd_* is set takes the ALU flag instead (flag update wins).
//    fw_we still pulses so the file copy is written.
//  - skip_out<=1 on commit with skip_en & alu_zout, else 0. Pulse only; never held.
//  - No commit (wb_valid=0 or hold=1): W, C, Z, fw_addr, fw_data hold;
//    fw_we<=0; skip_out<=0. Thus fw_we/skip_out never exceed one cycle per commit.
//  - Back-to-back commits every cycle are supported; each produces its own pulse.
//  - status_c change is visible on ALU cin the cycle after commit (ROR/ROL chains).
//  - byp_hit/byp_data purely combinational from registered state; no path from
//    alu_* inputs to any output (no combinational loop via cin).
// TESTING
//  - Reset: assert reset mid-commit of fw write -> all outputs to reset values
//    immediately, fw_we=0, w_out=8'h00 with no clock edge.
//  - ADD to W: alu_y=8'h3C, cout=1, zout=0, upd_c=upd_z=1, dest=0 -> next cycle
//    w_out=8'h3C, status_c=1, status_z=0, fw_we=0.
//  - File write + bypass: dest=1, addr=7'h20, y=8'hA5 -> fw_we pulse 1 cycle,
//    fw_addr=7'h20, fw_data=8'hA5; byp_addr=7'h20 -> byp_hit=1, 7'h21 -> 0.
//  - STATUS write: dest=1, addr=7'h03, y=8'h05, upd_z=1, zout=0 -> status_c=1,
//    status_z=0 (flag wins), status_out=8'h01, fw_we pulses.
//  - DECFSZ: skip_en=1, y=8'h00, zout=1, dest=1 -> skip_out=1 one cycle; repeat with
//    y=8'h01, zout=0 -> skip_out stays 0.
//  - Hold: hold=1 with wb_valid=1, y=8'hFF -> W/C/Z unchanged, fw_we=0, skip_out=0;
//    release hold -> commit occurs on next edge.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage behind the 8-bit ALU: commits the ALU result to W or to a
// registered file-write port, and maintains the STATUS C/Z flags.
// It also raises the DECFSZ/INCFSZ skip pulse and exposes a bypass of the
// pending file write to the upstream read stage.
module alu_writeback #(
  parameter logic [6:0] STATUS_ADDR = 7'h03,
  parameter logic [7:0] W_RESET     = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_valid,
  input  logic       hold,
  input  logic [7:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_zout,
  input  logic       wb_dest,
  input  logic [6:0] wb_addr,
  input  logic       upd_c,
  input  logic       upd_z,
  input  logic       skip_en,
  input  logic [6:0] byp_addr,
  output logic [7:0] w_out,
  output logic       status_c,
  output logic       status_z,
  output logic [7:0] status_out,
  output logic       fw_we,
  output logic [6:0] fw_addr,
  output logic [7:0] fw_data,
  output logic       skip_out,
  output logic       byp_hit,
  output logic [7:0] byp_data
);

  logic       commit;
  logic [7:0] w_q, w_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       fw_we_q, fw_we_d;
  logic [6:0] fw_addr_q, fw_addr_d;
  logic [7:0] fw_data_q, fw_data_d;
  logic       skip_q, skip_d;

  // hold freezes the pipe even when the ALU presents a valid result
  assign commit = wb_valid & ~hold;

  // Next-state: everything holds except the two pulses, which self-clear
  always_comb begin
    w_d       = w_q;
    c_d       = c_q;
    z_d       = z_q;
    fw_we_d   = 1'b0;
    fw_addr_d = fw_addr_q;
    fw_data_d = fw_data_q;
    skip_d    = 1'b0;
    if (commit) begin
      if (!wb_dest) begin
        w_d = alu_y;
      end else begin
        fw_we_d   = 1'b1;
        fw_addr_d = wb_addr;
        fw_data_d = alu_y;
        // Writing STATUS through the file port loads the flags from the data;
        // the flag updates below are applied afterwards so they take priority.
        if (wb_addr == STATUS_ADDR) begin
          c_d = alu_y[0];
          z_d = alu_y[2];
        end
      end
      if (upd_c) c_d = alu_cout;
      if (upd_z) z_d = alu_zout;
      skip_d = skip_en & alu_zout;
    end
  end

  // State registers; reset drops any pending write or skip
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q       <= W_RESET;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      fw_we_q   <= 1'b0;
      fw_addr_q <= 7'h00;
      fw_data_q <= 8'h00;
      skip_q    <= 1'b0;
    end else begin
      w_q       <= w_d;
      c_q       <= c_d;
      z_q       <= z_d;
      fw_we_q   <= fw_we_d;
      fw_addr_q <= fw_addr_d;
      fw_data_q <= fw_data_d;
      skip_q    <= skip_d;
    end
  end

  // Outputs come only from registered state, so status_c -> ALU cin cannot loop
  assign w_out      = w_q;
  assign status_c   = c_q;
  assign status_z   = z_q;
  assign status_out = {5'b0, z_q, 1'b0, c_q};
  assign fw_we      = fw_we_q;
  assign fw_addr    = fw_addr_q;
  assign fw_data    = fw_data_q;
  assign skip_out   = skip_q;
  assign byp_hit    = fw_we_q & (byp_addr == fw_addr_q);
  assign byp_data   = fw_data_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios then randomized commits, each
// cycle compared against a byte-level model of W, the STATUS register and
// the pending file write.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_valid, hold, alu_cout, alu_zout, wb_dest, upd_c, upd_z, skip_en;
  logic [7:0] alu_y;
  logic [6:0] wb_addr, byp_addr;
  logic [7:0] w_out, status_out, fw_data, byp_data;
  logic       status_c, status_z, fw_we, skip_out, byp_hit;
  logic [6:0] fw_addr;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: W, STATUS as a byte, and the last file write
  logic [7:0] m_w, m_status, m_fdata;
  logic [6:0] m_faddr;
  logic       m_fwe, m_skip;

  alu_writeback dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .hold(hold),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_zout(alu_zout),
    .wb_dest(wb_dest), .wb_addr(wb_addr), .upd_c(upd_c), .upd_z(upd_z),
    .skip_en(skip_en), .byp_addr(byp_addr), .w_out(w_out),
    .status_c(status_c), .status_z(status_z), .status_out(status_out),
    .fw_we(fw_we), .fw_addr(fw_addr), .fw_data(fw_data),
    .skip_out(skip_out), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_w = 8'h00; m_status = 8'h00; m_fdata = 8'h00; m_faddr = 7'h00;
    m_fwe = 1'b0; m_skip = 1'b0;
  endtask

  // Applies one clock edge worth of architectural effect
  task automatic model_edge();
    m_fwe  = 1'b0;
    m_skip = 1'b0;
    if (wb_valid && !hold) begin
      if (wb_dest) begin
        m_fwe = 1'b1; m_faddr = wb_addr; m_fdata = alu_y;
        if (wb_addr == 7'h03) m_status = alu_y & 8'h05;
      end else begin
        m_w = alu_y;
      end
      if (upd_c) m_status = (m_status & 8'hFE) | {7'b0, alu_cout};
      if (upd_z) m_status = (m_status & 8'hFB) | {5'b0, alu_zout, 2'b0};
      m_skip = skip_en && (alu_y == 8'h00);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w"},      w_out,      m_w);
    chk({tag, ".c"},      status_c,   m_status[0]);
    chk({tag, ".z"},      status_z,   m_status[2]);
    chk({tag, ".stat"},   status_out, m_status);
    chk({tag, ".fwe"},    fw_we,      m_fwe);
    chk({tag, ".faddr"},  fw_addr,    m_faddr);
    chk({tag, ".fdata"},  fw_data,    m_fdata);
    chk({tag, ".skip"},   skip_out,   m_skip);
    chk({tag, ".bhit"},   byp_hit,    m_fwe && (byp_addr == m_faddr));
    chk({tag, ".bdata"},  byp_data,   m_fdata);
  endtask

  task automatic drive(input logic v, h, d, input logic [6:0] a, input logic [7:0] y,
                       input logic co, uc, uz, se);
    wb_valid = v; hold = h; wb_dest = d; wb_addr = a; alu_y = y;
    alu_cout = co; alu_zout = (y == 8'h00); upd_c = uc; upd_z = uz; skip_en = se;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    byp_addr = 7'h00;
    drive(0, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("rst");
    reset = 1'b0;

    // ADD into W with both flags updated
    drive(1, 0, 0, 7'h00, 8'h3C, 1, 1, 1, 0);
    cycle("add");
    chk("add.w_lit", w_out, 8'h3C);
    drive(0, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0);
    cycle("idle0");

    // File write and bypass
    drive(1, 0, 1, 7'h20, 8'hA5, 0, 0, 0, 0);
    byp_addr = 7'h20;
    cycle("fw");
    chk("fw.hit_lit", byp_hit, 1'b1);
    chk("fw.data_lit", byp_data, 8'hA5);
    byp_addr = 7'h21;
    #1 chk("fw.miss", byp_hit, 1'b0);
    drive(0, 0, 0, 7'h00, 8'h00, 0, 0, 0, 0);
    byp_addr = 7'h20;
    cycle("fw_end");
    chk("fw.pulse_end", fw_we, 1'b0);

    // STATUS written through the file port; Z update wins over data bit 2
    drive(1, 0, 1, 7'h03, 8'h05, 0, 0, 1, 0);
    cycle("stat");
    chk("stat.lit", status_out, 8'h01);

    // DECFSZ reaching zero, then not reaching zero
    drive(1, 0, 1, 7'h30, 8'h00, 0, 0, 0, 1);
    cycle("dz");
    chk("dz.skip_lit", skip_out, 1'b1);
    drive(1, 0, 1, 7'h30, 8'h01, 0, 0, 0, 1);
    cycle("dnz");
    chk("dnz.skip_lit", skip_out, 1'b0);

    // Hold overrides valid, release commits on the next edge
    drive(1, 1, 0, 7'h00, 8'hFF, 1, 1, 1, 1);
    cycle("hold");
    cycle("hold2");
    hold = 1'b0;
    cycle("rel");
    chk("rel.w_lit", w_out, 8'hFF);

    // Asynchronous reset in the middle of a file write pulse
    drive(1, 0, 1, 7'h44, 8'h5A, 1, 1, 0, 0);
    cycle("pre_rst");
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    reset = 1'b0;

    // Randomized traffic, addresses biased towards STATUS and a bypass target
    for (int i = 0; i < 400; i++) begin
      logic [6:0] a;
      logic [7:0] y;
      case ($urandom_range(0, 3))
        0: a = 7'h03;
        1: a = 7'h20;
        default: a = 7'($urandom);
      endcase
      y = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom), a, y,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      byp_addr = $urandom_range(0, 1) ? m_faddr : 7'($urandom);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
